// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-wide RAM sequencer: FSM states, load/store size codes,
// grant ids and the default IO region tag.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_IC_RD,
        ST_LS_RD,
        ST_LS_WR,
        ST_DONE
    } state_t;

    localparam logic [1:0] SZ_1B  = 2'd0;
    localparam logic [1:0] SZ_2B  = 2'd1;
    localparam logic [1:0] SZ_4B  = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    localparam logic [1:0] IO_BASE_HI_DFLT = 2'b11;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_LS = 1'b1;

    // The reserved size code falls through to a full word.
    function automatic logic [4:0] ls_nbytes(input logic [1:0] size);
        case (size)
            SZ_1B:   ls_nbytes = 5'd1;
            SZ_2B:   ls_nbytes = 5'd2;
            default: ls_nbytes = 5'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way round-robin grant between ICache and LSB, with flush and done masking.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic rdy,
    input  logic idle,
    input  logic ic_req,
    input  logic ic_done,
    input  logic ls_req,
    input  logic ls_we,
    input  logic ls_done,
    input  logic flush,
    input  logic io_block,
    output logic gnt_vld,
    output logic gnt_id
);

    logic last_grant;
    logic ic_ok;
    logic ls_ok;

    // A requester whose done is showing this cycle is still holding a stale request.
    always_comb begin
        ic_ok   = ic_req & ~ic_done & ~flush;
        ls_ok   = ls_req & ~ls_done & ~(flush & ~ls_we) & ~io_block;
        gnt_vld = idle & (ic_ok | ls_ok);
        if (ic_ok && ls_ok) begin
            gnt_id = (last_grant == GNT_IC) ? GNT_LS : GNT_IC;
        end else begin
            gnt_id = ls_ok ? GNT_LS : GNT_IC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_IC;
        end else if (rdy && gnt_vld) begin
            last_grant <= gnt_id;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM port sequencer shared by ICache fetches and LSB loads/stores (little-endian).
// Optional IO_FULL_STALL_EN holds back IO-region stores while the IO buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int IC_BYTES = 4
`ifdef IO_FULL_STALL_EN
    ,
    parameter logic [1:0] IO_BASE_HI = IO_BASE_HI_DFLT
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr,
    input  logic                  ic_req,
    input  logic [ADDR_W-1:0]     ic_addr,
    output logic                  ic_done,
    output logic [IC_BYTES*8-1:0] ic_data,
    input  logic                  ls_req,
    input  logic                  ls_we,
    input  logic [ADDR_W-1:0]     ls_addr,
    input  logic [1:0]            ls_size,
    input  logic [31:0]           ls_wdata,
    output logic                  ls_done,
    output logic [31:0]           ls_rdata,
`ifdef IO_FULL_STALL_EN
    input  logic                  io_buffer_full,
`endif
    input  logic                  flush
);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q;
    logic [3:0]         nxt;
    logic [4:0]         nbytes_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [3:0][7:0]    wdata_q;
    logic [15:0][7:0]   bytes_q;
    logic [15:0][7:0]   fill;
    logic               src_q;
    logic               mem_wr_q;
    logic               last;
    logic               gnt_vld;
    logic               gnt_id;
    logic               io_block;

`ifdef IO_FULL_STALL_EN
    assign io_block = io_buffer_full & ls_we & (ls_addr[17:16] == IO_BASE_HI);
`else
    assign io_block = 1'b0;
`endif

    mem_ctrl_arb u_arb (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .idle     (state_q == ST_IDLE),
        .ic_req   (ic_req),
        .ic_done  (ic_done),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_done  (ls_done),
        .flush    (flush),
        .io_block (io_block),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    assign nxt    = cnt_q + 4'd1;
    assign last   = ({1'b0, cnt_q} == (nbytes_q - 5'd1));
    assign mem_wr = mem_wr_q & rdy;

    // Byte arriving now belongs to the address issued last cycle.
    always_comb begin
        fill        = bytes_q;
        fill[cnt_q] = mem_din;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    if (gnt_id == GNT_IC)  state_d = ST_IC_RD;
                    else if (ls_we)        state_d = ST_LS_WR;
                    else                   state_d = ST_LS_RD;
                end
            end
            ST_IC_RD, ST_LS_RD: begin
                if (flush)     state_d = ST_IDLE;
                else if (last) state_d = ST_DONE;
            end
            ST_LS_WR: if (last) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            nbytes_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            bytes_q  <= '0;
            src_q    <= GNT_IC;
            mem_a    <= '0;
            mem_dout <= '0;
            mem_wr_q <= 1'b0;
            ic_done  <= 1'b0;
            ic_data  <= '0;
            ls_done  <= 1'b0;
            ls_rdata <= '0;
        end else if (rdy) begin
            ic_done <= 1'b0;
            ls_done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        cnt_q   <= '0;
                        bytes_q <= '0;
                        src_q   <= gnt_id;
                        if (gnt_id == GNT_IC) begin
                            addr_q   <= ic_addr;
                            nbytes_q <= 5'(IC_BYTES);
                            mem_a    <= ic_addr;
                        end else begin
                            addr_q   <= ls_addr;
                            nbytes_q <= ls_nbytes(ls_size);
                            wdata_q  <= ls_wdata;
                            mem_a    <= ls_addr;
                            mem_wr_q <= ls_we;
                            mem_dout <= ls_we ? ls_wdata[7:0] : 8'h00;
                        end
                    end
                end
                ST_IC_RD, ST_LS_RD: begin
                    if (cnt_q != 4'd0) bytes_q[cnt_q - 4'd1] <= mem_din;
                    if (flush || last) begin
                        mem_a <= '0;
                    end else begin
                        mem_a <= addr_q + ADDR_W'(nxt);
                        cnt_q <= nxt;
                    end
                end
                ST_DONE: begin
                    if (!flush) begin
                        if (src_q == GNT_IC) begin
                            ic_done <= 1'b1;
                            ic_data <= fill[IC_BYTES-1:0];
                        end else begin
                            ls_done  <= 1'b1;
                            ls_rdata <= fill[3:0];
                        end
                    end
                end
                ST_LS_WR: begin
                    if (last) begin
                        mem_a    <= '0;
                        mem_dout <= 8'h00;
                        mem_wr_q <= 1'b0;
                        ls_done  <= 1'b1;
                    end else begin
                        mem_a    <= addr_q + ADDR_W'(nxt);
                        mem_dout <= wdata_q[nxt[1:0]];
                        cnt_q    <= nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: table of single transactions plus contention, flush, rdy,
// reset and optional IO-stall sequences, against a small byte RAM model.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = '0;
    logic        ic_done;
    logic [31:0] ic_data;
    logic        ls_req = 1'b0;
    logic        ls_we = 1'b0;
    logic [31:0] ls_addr = '0;
    logic [1:0]  ls_size = '0;
    logic [31:0] ls_wdata = '0;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        flush = 1'b0;
`ifdef IO_FULL_STALL_EN
    logic        io_buffer_full = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    mem_ctrl #(.ADDR_W(32), .IC_BYTES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .ic_req   (ic_req),
        .ic_addr  (ic_addr),
        .ic_done  (ic_done),
        .ic_data  (ic_data),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_size  (ls_size),
        .ls_wdata (ls_wdata),
        .ls_done  (ls_done),
        .ls_rdata (ls_rdata),
`ifdef IO_FULL_STALL_EN
        .io_buffer_full (io_buffer_full),
`endif
        .flush    (flush)
    );

    always #5 clk = ~clk;

    // Preloaded contents; anything stored during the run overrides them.
    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h0000_0100: rom = 8'h13;
            32'h0000_0103: rom = 8'h93;
            32'h0000_3000: rom = 8'h11;
            32'h0000_3001: rom = 8'h22;
            32'h0000_3002: rom = 8'h33;
            32'h0000_3003: rom = 8'h44;
            32'hFFFF_FFFE: rom = 8'hA1;
            32'hFFFF_FFFF: rom = 8'hB2;
            32'h0000_0000: rom = 8'hC3;
            32'h0000_0001: rom = 8'hD4;
            default:       rom = 8'h00;
        endcase
    endfunction

    logic [7:0] wram [bit [31:0]];

    always @(posedge clk) begin
        if (rdy) mem_din <= wram.exists(mem_a) ? wram[mem_a] : rom(mem_a);
    end

    always @(posedge clk) begin
        if (rdy && mem_wr) wram[mem_a] = mem_dout;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    typedef struct {
        logic        is_ic;
        logic        we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          n;
        logic        fl;
    } vec_t;

    task automatic do_txn(input vec_t v, input int idx);
        int          done_k;
        logic [31:0] dat;
        logic [31:0] sh;
        done_k = -1;
        dat    = '0;
        flush  = v.fl;
        if (v.is_ic) begin
            ic_req  = 1'b1;
            ic_addr = v.addr;
        end else begin
            ls_req   = 1'b1;
            ls_we    = v.we;
            ls_addr  = v.addr;
            ls_size  = v.size;
            ls_wdata = v.wdata;
        end
        for (int k = 1; k <= 20 && done_k < 0; k++) begin
            step();
            if (k <= v.n) begin
                sh = v.wdata >> (8 * (k - 1));
                check($sformatf("v%0d addr c%0d", idx, k), mem_a, v.addr + 32'(k - 1));
                check($sformatf("v%0d wr c%0d", idx, k), {31'd0, mem_wr}, {31'd0, v.we});
                check($sformatf("v%0d dout c%0d", idx, k), {24'd0, mem_dout},
                      v.we ? {24'd0, sh[7:0]} : 32'd0);
            end else if (k == v.n + 1) begin
                check($sformatf("v%0d idle addr", idx), mem_a, 32'd0);
            end
            if (v.is_ic ? ic_done : ls_done) begin
                done_k = k;
                dat    = v.is_ic ? ic_data : ls_rdata;
                ic_req = 1'b0;
                ls_req = 1'b0;
            end
        end
        ic_req = 1'b0;
        ls_req = 1'b0;
        flush  = 1'b0;
        check($sformatf("v%0d done cycle", idx), done_k, v.we ? v.n + 1 : v.n + 2);
        if (!v.we) check($sformatf("v%0d data", idx), dat, v.exp_data);
        step();
    endtask

    vec_t vecs[12];

    initial begin
        int          done_k;
        int          seen;
        int          nev;
        logic        ev_ic [4];
        int          ev_cyc [4];

        vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0100, 32'h0,         32'h9300_0013, 4, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd1, 32'h0000_2000, 32'hAABB_CCDD, 32'h0,         2, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 2'd0, 32'h0000_3000, 32'h0,         32'h0000_0011, 1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 2'd1, 32'h0000_3000, 32'h0,         32'h0000_2211, 2, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'd2, 32'h0000_3000, 32'h0,         32'h4433_2211, 4, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0,         32'hD4C3_B2A1, 4, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'd2, 32'h0000_2004, 32'h0102_0304, 32'h0,         4, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 2'd2, 32'h0000_2000, 32'h0,         32'h0000_CCDD, 4, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 2'd3, 32'h0000_2004, 32'h0,         32'h0102_0304, 4, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A, 32'h0,         1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h0000_2010, 32'h1122_3344, 32'h0,         4, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'd0, 32'h0000_3000, 32'h0,         32'h4433_2211, 4, 1'b0};

        step();
        step();
        check("rst mem_a", mem_a, 32'd0);
        check("rst mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst mem_dout", {24'd0, mem_dout}, 32'd0);
        check("rst ic_done", {31'd0, ic_done}, 32'd0);
        check("rst ls_done", {31'd0, ls_done}, 32'd0);
        check("rst ic_data", ic_data, 32'd0);
        check("rst ls_rdata", ls_rdata, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 12; i++) do_txn(vecs[i], i);

        // Flush mid-fetch: abort, address bus idles, no done.
        ic_addr = 32'h100;
        ic_req  = 1'b1;
        step();
        step();
        step();
        check("flush a c3", mem_a, 32'h102);
        flush  = 1'b1;
        ic_req = 1'b0;
        step();
        flush = 1'b0;
        check("flush a c4", mem_a, 32'd0);
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (ic_done || mem_a != 32'd0) seen = 1;
        end
        check("flush no done", seen, 0);
        check("flush ic_data hold", ic_data, 32'h4433_2211);

        // rdy low for three cycles mid-load delays done by three.
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_size = 2'd2;
        ls_addr = 32'h3000;
        done_k  = -1;
        for (int k = 1; k <= 20 && done_k < 0; k++) begin
            step();
            if (k == 2) rdy = 1'b0;
            if (k >= 3 && k <= 5) begin
                check($sformatf("rdy hold a c%0d", k), mem_a, 32'h3001);
                check($sformatf("rdy wr c%0d", k), {31'd0, mem_wr}, 32'd0);
            end
            if (k == 5) rdy = 1'b1;
            if (ls_done) begin
                done_k = k;
                check("rdy data", ls_rdata, 32'h4433_2211);
                ls_req = 1'b0;
            end
        end
        ls_req = 1'b0;
        check("rdy done cycle", done_k, 9);
        step();

        // rdy low during a store cycle masks mem_wr and stretches the store.
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_size  = 2'd0;
        ls_addr  = 32'h2040;
        ls_wdata = 32'h77;
        step();
        check("st rdy wr on", {31'd0, mem_wr}, 32'd1);
        rdy = 1'b0;
        #1;
        check("st rdy wr masked", {31'd0, mem_wr}, 32'd0);
        step();
        check("st rdy no done", {31'd0, ls_done}, 32'd0);
        check("st rdy wr frozen", {31'd0, mem_wr}, 32'd0);
        rdy = 1'b1;
        #1;
        check("st rdy wr back", {31'd0, mem_wr}, 32'd1);
        step();
        check("st rdy done", {31'd0, ls_done}, 32'd1);
        ls_req = 1'b0;
        step();

        // Reset in the middle of a store.
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_size  = 2'd2;
        ls_addr  = 32'h2030;
        ls_wdata = 32'hDEAD_BEEF;
        step();
        step();
        check("mid st wr", {31'd0, mem_wr}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid rst wr", {31'd0, mem_wr}, 32'd0);
        check("mid rst a", mem_a, 32'd0);
        check("mid rst dout", {24'd0, mem_dout}, 32'd0);
        check("mid rst rdata", ls_rdata, 32'd0);
        check("mid rst icdata", ic_data, 32'd0);
        step();
        rst    = 1'b0;
        ls_req = 1'b0;
        seen   = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (ls_done || mem_wr) seen = 1;
        end
        check("mid rst no retry", seen, 0);

        // Both requesting from reset: LS first, then strict alternation.
        ic_addr = 32'h100;
        ic_req  = 1'b1;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_size = 2'd0;
        ls_addr = 32'h3000;
        nev     = 0;
        for (int k = 0; k < 4; k++) begin
            ev_ic[k]  = 1'b0;
            ev_cyc[k] = -1;
        end
        for (int k = 1; k <= 30 && nev < 4; k++) begin
            step();
            if (k == 1) check("cont first a", mem_a, 32'h3000);
            if (ls_done && nev < 4) begin
                ev_ic[nev] = 1'b0; ev_cyc[nev] = k; nev++;
                check("cont ls data", ls_rdata, 32'h11);
            end
            if (ic_done && nev < 4) begin
                ev_ic[nev] = 1'b1; ev_cyc[nev] = k; nev++;
                check("cont ic data", ic_data, 32'h9300_0013);
            end
            if (nev >= 4) begin
                ic_req = 1'b0;
                ls_req = 1'b0;
            end
        end
        ic_req = 1'b0;
        ls_req = 1'b0;
        check("cont ev0", {ev_ic[0], 31'(ev_cyc[0])}, {1'b0, 31'd3});
        check("cont ev1", {ev_ic[1], 31'(ev_cyc[1])}, {1'b1, 31'd9});
        check("cont ev2", {ev_ic[2], 31'(ev_cyc[2])}, {1'b0, 31'd12});
        check("cont ev3", {ev_ic[3], 31'(ev_cyc[3])}, {1'b1, 31'd18});
        step();
        step();

`ifdef IO_FULL_STALL_EN
        // IO store waits for the buffer to drain, then runs normally.
        io_buffer_full = 1'b1;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_size  = 2'd0;
        ls_addr  = 32'h0003_0000;
        ls_wdata = 32'h5A;
        seen = 0;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (mem_wr || ls_done) seen = 1;
        end
        check("io stalled", seen, 0);
        io_buffer_full = 1'b0;
        step();
        check("io wr", {31'd0, mem_wr}, 32'd1);
        check("io addr", mem_a, 32'h0003_0000);
        step();
        check("io done", {31'd0, ls_done}, 32'd1);
        ls_req = 1'b0;
        step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
